cfg_write_arbiter: RTL and testbench

- Owns the five 8-bit peripheral configuration registers: output enables, PWM enables and PWM duty.
- Shares write access between two requesters:
  - Port A: the SPI command decoder, already synchronised into `clk`.
  - Port B: an on-chip sequencer.
- PWM-related registers are double-buffered, so duty and enable changes land only on a PWM period boundary.
- Sits between the SPI front-end and the PWM/output-mux logic in the top level.

---
 rtl/cfg_write_arbiter.sv | 130 +++++++++++++
 tb/tb_cfg_write_arbiter.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/cfg_write_arbiter.sv
// Two-port write arbiter owning the five peripheral config registers; regs 2-4 are
// shadowed and commit on period_start. Define CFG_ARB_ROUND_ROBIN_EN for round-robin ties.
module cfg_write_arbiter #(
  parameter int unsigned MAX_ADDR = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       a_valid,
  input  logic [6:0] a_addr,
  input  logic [7:0] a_data,
  output logic       a_ready,
  input  logic       b_valid,
  input  logic [6:0] b_addr,
  input  logic [7:0] b_data,
  output logic       b_ready,
  input  logic       period_start,
  output logic [7:0] en_out,
  output logic [7:0] en_uio,
  output logic [7:0] pwm_en_out,
  output logic [7:0] pwm_en_uio,
  output logic [7:0] duty,
  output logic [2:0] pending,
  output logic       err_pulse,
  output logic [3:0] err_count
);

  typedef enum logic [1:0] {IDLE, ACCEPT, APPLY} state_t;

  state_t     state, state_nxt;
  logic       grant, grant_nxt;   // 0 = port A, 1 = port B
  logic       capture;
  logic       granted_valid;
  logic       tie_pick_b;
  logic [6:0] hold_addr;
  logic [7:0] hold_data;
  logic [7:0] shadow_pwm_out, shadow_pwm_uio, shadow_duty;
  logic       addr_err, wr_ok;
  logic [2:0] shadow_wr;

  assign granted_valid = grant ? b_valid : a_valid;

`ifdef CFG_ARB_ROUND_ROBIN_EN
  logic last_win;

  // Reset to B so that A wins the first tie.
  always_ff @(posedge clk) begin
    if (rst)          last_win <= 1'b1;
    else if (capture) last_win <= grant;
  end

  assign tie_pick_b = ~last_win;
`else
  assign tie_pick_b = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (a_valid || b_valid) begin
          grant_nxt = (a_valid && b_valid) ? tie_pick_b : b_valid;
          state_nxt = ACCEPT;
        end
      end
      ACCEPT: begin
        if (granted_valid) begin
          capture   = 1'b1;
          state_nxt = APPLY;
        end else begin
          state_nxt = IDLE;
        end
      end
      APPLY:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign a_ready = (state == ACCEPT) && !grant;
  assign b_ready = (state == ACCEPT) && grant;

  always_comb begin
    addr_err     = (state == APPLY) && ({25'd0, hold_addr} > MAX_ADDR);
    wr_ok        = (state == APPLY) && !addr_err;
    shadow_wr[0] = wr_ok && (hold_addr == 7'd2);
    shadow_wr[1] = wr_ok && (hold_addr == 7'd3);
    shadow_wr[2] = wr_ok && (hold_addr == 7'd4);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      grant          <= 1'b0;
      hold_addr      <= '0;
      hold_data      <= '0;
      en_out         <= '0;
      en_uio         <= '0;
      pwm_en_out     <= '0;
      pwm_en_uio     <= '0;
      duty           <= '0;
      shadow_pwm_out <= '0;
      shadow_pwm_uio <= '0;
      shadow_duty    <= '0;
      pending        <= '0;
      err_pulse      <= 1'b0;
      err_count      <= '0;
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
      if (capture) begin
        hold_addr <= grant ? b_addr : a_addr;
        hold_data <= grant ? b_data : a_data;
      end
      err_pulse <= addr_err;
      if (addr_err && (err_count != 4'hF)) err_count <= err_count + 4'd1;
      if (wr_ok && (hold_addr == 7'd0)) en_out <= hold_data;
      if (wr_ok && (hold_addr == 7'd1)) en_uio <= hold_data;
      // Commit reads the old pending/shadow; a same-cycle APPLY stays pending.
      if (period_start && pending[0]) pwm_en_out <= shadow_pwm_out;
      if (period_start && pending[1]) pwm_en_uio <= shadow_pwm_uio;
      if (period_start && pending[2]) duty       <= shadow_duty;
      if (shadow_wr[0]) shadow_pwm_out <= hold_data;
      if (shadow_wr[1]) shadow_pwm_uio <= hold_data;
      if (shadow_wr[2]) shadow_duty    <= hold_data;
      pending <= (pending & {3{~period_start}}) | shadow_wr;
    end
  end

endmodule

// File: tb/tb_cfg_write_arbiter.sv
// Self-checking bench for cfg_write_arbiter: directed scenarios plus random writes
// against a register-level reference model.
module tb_cfg_write_arbiter;

  localparam int unsigned MAXA = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       a_valid, b_valid, period_start;
  logic [6:0] a_addr, b_addr;
  logic [7:0] a_data, b_data;
  logic       a_ready, b_ready;
  logic [7:0] en_out, en_uio, pwm_en_out, pwm_en_uio, duty;
  logic [2:0] pending;
  logic       err_pulse;
  logic [3:0] err_count;

  int total = 0;
  int bad   = 0;

  logic [7:0] m_live [5];
  logic [7:0] m_shad [5];
  bit         m_pend [5];
  int         m_err;

  always #5 clk = ~clk;

  cfg_write_arbiter #(.MAX_ADDR(MAXA)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
    .period_start(period_start),
    .en_out(en_out), .en_uio(en_uio), .pwm_en_out(pwm_en_out), .pwm_en_uio(pwm_en_uio),
    .duty(duty), .pending(pending), .err_pulse(err_pulse), .err_count(err_count)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic m_clear();
    for (int k = 0; k < 5; k++) begin
      m_live[k] = '0; m_shad[k] = '0; m_pend[k] = 0;
    end
    m_err = 0;
  endtask

  task automatic m_commit();
    for (int k = 2; k < 5; k++)
      if (m_pend[k]) begin m_live[k] = m_shad[k]; m_pend[k] = 0; end
  endtask

  task automatic m_write(input int addr, input logic [7:0] data);
    if (addr > int'(MAXA)) m_err = (m_err < 15) ? m_err + 1 : 15;
    else if (addr < 2) m_live[addr] = data;
    else if (addr <= 4) begin m_shad[addr] = data; m_pend[addr] = 1; end
  endtask

  task automatic check_all(input string tag, input bit exp_err);
    chk({tag, ".en_out"},     en_out,     m_live[0]);
    chk({tag, ".en_uio"},     en_uio,     m_live[1]);
    chk({tag, ".pwm_en_out"}, pwm_en_out, m_live[2]);
    chk({tag, ".pwm_en_uio"}, pwm_en_uio, m_live[3]);
    chk({tag, ".duty"},       duty,       m_live[4]);
    chk({tag, ".pending"},    {5'd0, pending}, {5'd0, m_pend[4], m_pend[3], m_pend[2]});
    chk({tag, ".err_pulse"},  {7'd0, err_pulse}, {7'd0, exp_err});
    chk({tag, ".err_count"},  {4'd0, err_count}, 8'(m_err));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    a_valid = 0; b_valid = 0; period_start = 0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    m_clear();
    check_all("reset", 0);
    chk("reset.a_ready", {7'd0, a_ready}, 8'd0);
    chk("reset.b_ready", {7'd0, b_ready}, 8'd0);
  endtask

  // Entered and left 1 time unit after a rising edge, with the DUT idle.
  task automatic do_write(input string tag, input bit port, input logic [6:0] addr,
                          input logic [7:0] data, input bit ps);
    if (!port) begin a_valid = 1; a_addr = addr; a_data = data; end
    else       begin b_valid = 1; b_addr = addr; b_data = data; end
    chk({tag, ".rdy_n0"}, {6'd0, a_ready, b_ready}, 8'd0);
    @(posedge clk); #1;
    chk({tag, ".rdy_n1"}, {6'd0, a_ready, b_ready}, port ? 8'd1 : 8'd2);
    @(posedge clk); #1;
    a_valid = 0; b_valid = 0; period_start = ps;
    chk({tag, ".rdy_n2"}, {6'd0, a_ready, b_ready}, 8'd0);
    @(posedge clk); #1;
    period_start = 0;
    if (ps) m_commit();
    m_write(int'(addr), data);
    check_all({tag, ".n3"}, int'(addr) > int'(MAXA));
    @(posedge clk); #1;
    chk({tag, ".err_n4"}, {7'd0, err_pulse}, 8'd0);
  endtask

  task automatic pulse_ps(input string tag);
    period_start = 1;
    @(posedge clk); #1;
    period_start = 0;
    m_commit();
    check_all(tag, 0);
  endtask

  initial begin
    bit         win [3];
    bit         last;
    bit         rr;
    int         addr;
    logic [7:0] d;
    a_addr = '0; b_addr = '0; a_data = '0; b_data = '0;
`ifdef CFG_ARB_ROUND_ROBIN_EN
    rr = 1;
`else
    rr = 0;
`endif

    do_reset();
    do_write("a_wr0", 0, 7'd0, 8'hA5, 0);

    do_write("b_wr4", 1, 7'd4, 8'h80, 0);
    pulse_ps("commit4");

    do_write("err1", 0, 7'd7, 8'h33, 0);
    for (int i = 0; i < 19; i++) do_write("errsat", 0, 7'd7, 8'(i), 0);

    do_write("coinc", 0, 7'd2, 8'h0F, 1);
    pulse_ps("commit2");

    // Reset while the FSM is in ACCEPT for an addr-4 write.
    a_valid = 1; a_addr = 7'd4; a_data = 8'h5A;
    @(posedge clk); #1;
    chk("rstacc.a_ready", {7'd0, a_ready}, 8'd1);
    rst = 1; a_valid = 0;
    @(posedge clk); #1;
    rst = 0;
    m_clear();
    check_all("rstacc", 0);
    chk("rstacc.rdy", {6'd0, a_ready, b_ready}, 8'd0);
    do_write("post_rst", 0, 7'd1, 8'h3C, 0);

    // Both ports requesting continuously.
    do_reset();
    last = 1;
    for (int k = 0; k < 3; k++) begin
      win[k] = rr ? !last : 1'b0;
      last = win[k];
    end
    a_valid = 1; a_addr = 7'd0; a_data = 8'h11;
    b_valid = 1; b_addr = 7'd1; b_data = 8'h22;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      if (c == 8) begin a_valid = 0; b_valid = 0; end
      chk("arb.a_ready", {7'd0, a_ready}, {7'd0, (c % 3 == 1) && !win[c / 3]});
      chk("arb.b_ready", {7'd0, b_ready}, {7'd0, (c % 3 == 1) &&  win[c / 3]});
    end
    for (int k = 0; k < 3; k++) m_write(win[k] ? 1 : 0, win[k] ? 8'h22 : 8'h11);
    @(posedge clk); #1;
    check_all("arb", 0);

    // Random traffic from a single requester at a time.
    for (int i = 0; i < 40; i++) begin
      addr = ($urandom_range(0, 3) == 0) ? int'($urandom_range(5, 127)) : int'($urandom_range(0, 4));
      d = 8'($urandom);
      do_write("rnd", 1'($urandom), 7'(addr), d, ($urandom_range(0, 4) == 0));
      if ($urandom_range(0, 2) == 0) pulse_ps("rnd_ps");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
